task_sequencer: RTL and testbench
=================================

Name: task_sequencer

Overview:
Parametrised successor of the task-to-motion sequencer. It accepts already-parsed motion tasks (period, signed step counts and start velocities per axis) into an internal prefetch FIFO. On each step request it pops one task, converts it to per-axis motor parameters and issues a load pulse to the pulse computers. It then waits for completion and acknowledges the step. Compared with the previous sequencer it adds axis-count and width parametrisation, task prefetch depth, an N range check, a ready watchdog, sticky error codes and software recovery from the error state.

Parameters:
AXES, 8, number of motor channels
N_WIDTH, 24, width of unsigned step count delivered to computers
V_WIDTH, 32, width of per-axis start velocity V0
DEPTH, 4, prefetch FIFO depth in tasks (power of 2, >=2)
TIMEOUT, 1024, max cycles waiting for all comp_rdy before timeout error

Ports:
clk  in  1  system clock
sclr  in  1  synchronous active-high reset
abort  in  1  abort request; forces ERR
err_clr  in  1  leave ERR, clear error, flush FIFO
task_valid  in  1  parsed task present
task_ready  out  1  FIFO can accept a task
task_ts  in  32  step period
task_N  in  AXES*32  signed step count per axis, axis i at [32i+31:32i]
task_V0  in  AXES*V_WIDTH  start velocity per axis
task_empty  out  1  FIFO empty
task_count  out  $clog2(DEPTH)+1  tasks held in FIFO
step_req  in  1  request next step (level)
step_ack  out  1  step done (level, 4-phase)
load  out  1  one-cycle load strobe to computers
comp_rdy  in  AXES  per-computer ready
calc_error  in  1  computer error
ts  out  32  current period
mask  out  AXES  axis i active (N[i] != 0)
dir  out  AXES  axis i direction, 1 = N negative
N_abs  out  AXES*N_WIDTH  |N[i]|
V0  out  AXES*V_WIDTH  current start velocities
done_cnt  out  32  steps acknowledged since reset
busy  out  1  state != IDLE
error  out  4  sticky: [0] abort, [1] N range, [2] timeout, [3] calc_error

Behaviour:
- Reset (sclr, synchronous): state IDLE; FIFO empty; step_ack, load, ts, mask, dir, N_abs, V0, done_cnt and error = 0. task_ready = 1 from the first cycle after sclr is released.
- Priority: sclr > abort > calc_error > err_clr > normal operation.
- FIFO: write on task_valid && task_ready. task_ready = !full && state != ERR, so writes are refused when full even if a pop occurs in the same cycle. Simultaneous push and pop of a non-full FIFO leaves task_count unchanged. Pointers wrap modulo DEPTH.
- IDLE: if step_req && !task_empty, pop the head and register ts, V0, mask, dir and N_abs.
  - If any |N[i]| > 2^N_WIDTH-1 (including N = -2^31 when N_WIDTH < 32): error[1] = 1, go to ERR.
  - Otherwise go to LOAD and clear the watchdog.
- LOAD: when comp_rdy == all ones, assert load for exactly 1 cycle and go to CALC. Otherwise increment the watchdog; at TIMEOUT set error[2] and go to ERR.
- CALC: comp_rdy is ignored in the first cycle after the load strobe. From the second cycle, comp_rdy == all ones sets step_ack = 1, increments done_cnt (wraps at 2^32) and goes to ACK. The watchdog also applies in CALC.
- ACK: hold step_ack until step_req = 0, then clear step_ack and go to IDLE. The next step needs a fresh rising step_req.
- abort (any state): load = 0, step_ack = 0, error[0] = 1, go to ERR. FIFO contents are kept.
- calc_error = 1 (any state except ERR): error[3] = 1, load = 0, step_ack = 0, go to ERR.
- ERR: outputs held; task_ready = 0. err_clr: error = 0, FIFO flushed, go to IDLE. If abort is also active, abort wins and the block stays in ERR.
- Latency: step_req with a non-empty FIFO and ready computers gives load 2 cycles later. step_ack follows 1 cycle after comp_rdy is seen all-ones in CALC.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
- AXES=8, N_WIDTH=24: push task N0 = -5, N1 = 0, N2 = 100, ts = 1000; step_req; comp_rdy drops for 10 cycles -> load pulses once; mask = 0x05; dir = 0x01; N_abs[0] = 5, N_abs[2] = 100; step_ack after ready returns; done_cnt = 1.
- Push 5 tasks with DEPTH = 4 and no step_req -> 4 accepted, task_ready = 0, task_count = 4. One step, then push again -> accepted, task_count = 4.
- Task with N3 = 0x0100_0000 and N_WIDTH = 24 -> ERR, error = 4'b0010, no load. err_clr -> IDLE, task_empty = 1, error = 0.
- comp_rdy stuck at 0xFE in LOAD -> after exactly TIMEOUT cycles error[2] = 1, no load.
- abort in CALC together with err_clr -> ERR, error[0] = 1, step_ack = 0. err_clr alone next cycle -> IDLE.
- sclr asserted in ACK with step_req high -> next cycle state IDLE, step_ack = 0, done_cnt = 0, FIFO empty.

Source files
------------

// File: rtl/task_sequencer.sv
// Prefetches parsed motion tasks and, per step request, converts the head task into per-axis
// motor parameters, strobes the pulse computers and acknowledges the step (4-phase).
module task_sequencer #(
  parameter int unsigned AXES    = 8,
  parameter int unsigned N_WIDTH = 24,
  parameter int unsigned V_WIDTH = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_sclr,
  input  logic                    i_abort,
  input  logic                    i_err_clr,
  input  logic                    i_task_valid,
  output logic                    o_task_ready,
  input  logic [31:0]             i_task_ts,
  input  logic [AXES*32-1:0]      i_task_n,
  input  logic [AXES*V_WIDTH-1:0] i_task_v0,
  output logic                    o_task_empty,
  output logic [$clog2(DEPTH):0]  o_task_count,
  input  logic                    i_step_req,
  output logic                    o_step_ack,
  output logic                    o_load,
  input  logic [AXES-1:0]         i_comp_rdy,
  input  logic                    i_calc_error,
  output logic [31:0]             o_ts,
  output logic [AXES-1:0]         o_mask,
  output logic [AXES-1:0]         o_dir,
  output logic [AXES*N_WIDTH-1:0] o_n_abs,
  output logic [AXES*V_WIDTH-1:0] o_v0,
  output logic [31:0]             o_done_cnt,
  output logic                    o_busy,
  output logic [3:0]              o_error
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
  localparam logic [63:0] NMax = (64'd1 << N_WIDTH) - 64'd1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StAck, StErr} state_e;

  state_e r_state, w_state_next;

  logic [31:0]             r_fifo_ts [DEPTH];
  logic [AXES*32-1:0]      r_fifo_n  [DEPTH];
  logic [AXES*V_WIDTH-1:0] r_fifo_v0 [DEPTH];
  logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PtrW:0]           r_count;

  logic [WdW-1:0]          r_wdog;
  logic                    r_load, r_step_ack;
  logic [31:0]             r_ts, r_done_cnt;
  logic [AXES-1:0]         r_mask, r_dir;
  logic [AXES*N_WIDTH-1:0] r_n_abs;
  logic [AXES*V_WIDTH-1:0] r_v0;
  logic [3:0]              r_error;

  logic                    w_full, w_empty, w_ready, w_push, w_pop, w_flush;
  logic                    w_all_rdy, w_wd_expire, w_range_err;
  logic [3:0]              w_err_set;
  logic [AXES*32-1:0]      w_head_n;
  logic [AXES-1:0]         w_mask, w_dir;
  logic [AXES*N_WIDTH-1:0] w_n_abs;
  logic [31:0]             w_abs [AXES];

  assign w_head_n    = r_fifo_n[r_rd_ptr];
  assign w_all_rdy   = &i_comp_rdy;
  assign w_wd_expire = (r_wdog == WdLast);

  // Decode of the FIFO head: -2^31 maps to 2^31, which the range check rejects.
  always_comb begin
    w_mask      = '0;
    w_dir       = '0;
    w_n_abs     = '0;
    w_range_err = 1'b0;
    for (int i = 0; i < int'(AXES); i++) begin
      w_abs[i]  = w_head_n[32*i+31] ? (~w_head_n[32*i +: 32] + 32'd1) : w_head_n[32*i +: 32];
      w_mask[i] = |w_head_n[32*i +: 32];
      w_dir[i]  = w_head_n[32*i+31];
      w_n_abs[N_WIDTH*i +: N_WIDTH] = N_WIDTH'({32'd0, w_abs[i]});
      if ({32'd0, w_abs[i]} > NMax) w_range_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err_set    = 4'b0000;
    if (i_abort) begin
      w_state_next = StErr;
      w_err_set[0] = 1'b1;
    end else if (i_calc_error && r_state != StErr) begin
      w_state_next = StErr;
      w_err_set[3] = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: if (i_step_req && !w_empty) begin
          w_state_next = w_range_err ? StErr : StLoad;
          w_err_set[1] = w_range_err;
        end
        StLoad: if (w_all_rdy) begin
          w_state_next = StCalc;
        end else if (w_wd_expire) begin
          w_state_next = StErr;
          w_err_set[2] = 1'b1;
        end
        // r_load marks the strobe cycle, in which comp_rdy is still stale
        StCalc: if (w_all_rdy && !r_load) begin
          w_state_next = StAck;
        end else if (w_wd_expire) begin
          w_state_next = StErr;
          w_err_set[2] = 1'b1;
        end
        StAck:  if (!i_step_req) w_state_next = StIdle;
        StErr:  if (i_err_clr) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_full  = (r_count == CntFull);
    w_empty = (r_count == '0);
    w_ready = !w_full && (r_state != StErr);
    w_push  = i_task_valid && w_ready;
    w_pop   = (r_state == StIdle) && i_step_req && !w_empty && !i_abort && !i_calc_error;
    w_flush = (r_state == StErr) && i_err_clr && !i_abort;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_ts[r_wr_ptr] <= i_task_ts;
      r_fifo_n[r_wr_ptr]  <= i_task_n;
      r_fifo_v0[r_wr_ptr] <= i_task_v0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_wdog     <= '0;
      r_load     <= 1'b0;
      r_step_ack <= 1'b0;
      r_ts       <= '0;
      r_mask     <= '0;
      r_dir      <= '0;
      r_n_abs    <= '0;
      r_v0       <= '0;
      r_done_cnt <= '0;
      r_error    <= '0;
    end else begin
      r_load <= (r_state == StLoad) && (w_state_next == StCalc);
      if (r_state == StCalc && w_state_next == StAck) begin
        r_step_ack <= 1'b1;
        r_done_cnt <= r_done_cnt + 32'd1;
      end else if (w_state_next != StAck) begin
        r_step_ack <= 1'b0;
      end
      if (w_state_next != r_state) r_wdog <= '0;
      else if (r_state == StLoad || r_state == StCalc) r_wdog <= r_wdog + 1'b1;
      if (w_flush) r_error <= '0;
      else         r_error <= r_error | w_err_set;
      if (w_pop) begin
        r_ts    <= r_fifo_ts[r_rd_ptr];
        r_v0    <= r_fifo_v0[r_rd_ptr];
        r_mask  <= w_mask;
        r_dir   <= w_dir;
        r_n_abs <= w_n_abs;
      end
    end
  end

  assign o_task_ready = w_ready;
  assign o_task_empty = w_empty;
  assign o_task_count = r_count;
  assign o_step_ack   = r_step_ack;
  assign o_load       = r_load;
  assign o_ts         = r_ts;
  assign o_mask       = r_mask;
  assign o_dir        = r_dir;
  assign o_n_abs      = r_n_abs;
  assign o_v0         = r_v0;
  assign o_done_cnt   = r_done_cnt;
  assign o_busy       = (r_state != StIdle);
  assign o_error      = r_error;

endmodule

// File: tb/tb_task_sequencer.sv
// Scenario bench for task_sequencer: tasks pushed into a scoreboard on acceptance are
// popped and compared against the registered motor parameters at each load strobe.
module tb_task_sequencer;
  localparam int AXES = 8, NW = 24, VW = 32, DEPTH = 4, TIMEOUT = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sclr = 1'b1, abort = 1'b0, err_clr = 1'b0, task_valid = 1'b0;
  logic step_req = 1'b0, calc_error = 1'b0;
  logic [31:0] task_ts = '0;
  logic [AXES*32-1:0] task_n = '0;
  logic [AXES*VW-1:0] task_v0 = '0;
  logic [AXES-1:0] comp_rdy = '1;
  logic task_ready, task_empty, step_ack, load, busy;
  logic [$clog2(DEPTH):0] task_count;
  logic [31:0] ts, done_cnt;
  logic [AXES-1:0] mask, dir;
  logic [AXES*NW-1:0] n_abs;
  logic [AXES*VW-1:0] v0;
  logic [3:0] error;

  task_sequencer #(
    .AXES(AXES), .N_WIDTH(NW), .V_WIDTH(VW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_sclr(sclr), .i_abort(abort), .i_err_clr(err_clr),
    .i_task_valid(task_valid), .o_task_ready(task_ready), .i_task_ts(task_ts),
    .i_task_n(task_n), .i_task_v0(task_v0), .o_task_empty(task_empty),
    .o_task_count(task_count), .i_step_req(step_req), .o_step_ack(step_ack), .o_load(load),
    .i_comp_rdy(comp_rdy), .i_calc_error(calc_error), .o_ts(ts), .o_mask(mask), .o_dir(dir),
    .o_n_abs(n_abs), .o_v0(v0), .o_done_cnt(done_cnt), .o_busy(busy), .o_error(error)
  );

  typedef struct {
    logic [31:0]        ts;
    logic [AXES-1:0]    mask;
    logic [AXES-1:0]    dir;
    logic [AXES*NW-1:0] nabs;
    logic [AXES*VW-1:0] v0;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0, model_cnt = 0, load_cnt = 0;
  logic [31:0] model_done = '0;

  always @(posedge clk) begin
    #2;
    if (load === 1'b1) load_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1);
  end

  function automatic exp_t model(input logic [31:0] t, input logic [255:0] n,
                                 input logic [255:0] v);
    exp_t e;
    e.ts = t; e.v0 = v; e.mask = '0; e.dir = '0; e.nabs = '0;
    for (int i = 0; i < AXES; i++) begin
      longint s, a;
      s = longint'($signed(n[32*i +: 32]));
      a = (s < 0) ? -s : s;
      e.mask[i] = (s != 0);
      e.dir[i]  = (s < 0);
      e.nabs[NW*i +: NW] = a[NW-1:0];
    end
    return e;
  endfunction

  function automatic logic [255:0] rand_v0();
    logic [255:0] v;
    for (int i = 0; i < AXES; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge, with no pop in the same cycle.
  task automatic push_task(input logic [31:0] t, input logic [255:0] n, input logic [255:0] v);
    task_valid = 1'b1; task_ts = t; task_n = n; task_v0 = v;
    if (model_cnt < DEPTH) begin
      sb.push_back(model(t, n, v));
      model_cnt++;
    end
    @(negedge clk);
    task_valid = 1'b0;
  endtask

  task automatic step_once(input int gap);
    exp_t e;
    step_req = 1'b1; comp_rdy = '1;
    @(negedge clk);
    checks++;
    if (load !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL step_pre load=%0b busy=%0b want 0 1", load, busy);
    end
    @(negedge clk);
    checks++;
    if (load !== 1'b1) begin failures++; $display("FAIL step_latency load=%0b want 1", load); end
    e = sb.pop_front(); model_cnt--;
    checks++;
    if (ts !== e.ts || mask !== e.mask || dir !== e.dir || n_abs !== e.nabs || v0 !== e.v0) begin
      failures++;
      $display("FAIL step_fields ts=%0d/%0d mask=%h/%h dir=%h/%h nabs=%h/%h v0=%h/%h",
               ts, e.ts, mask, e.mask, dir, e.dir, n_abs, e.nabs, v0, e.v0);
    end
    if (gap > 0) comp_rdy = '0;
    @(negedge clk);
    checks++;
    if (load !== 1'b0) begin failures++; $display("FAIL load_width load=%0b want 0", load); end
    if (gap > 1) repeat (gap - 1) @(negedge clk);
    comp_rdy = '1;
    for (int i = 0; i < 20 && step_ack !== 1'b1; i++) @(negedge clk);
    model_done++;
    checks++;
    if (step_ack !== 1'b1 || done_cnt !== model_done) begin
      failures++;
      $display("FAIL step_ack ack=%0b done=%0d want 1 %0d", step_ack, done_cnt, model_done);
    end
    step_req = 1'b0;
    @(negedge clk);
    checks++;
    if (step_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL step_release ack=%0b busy=%0b want 0 0", step_ack, busy);
    end
  endtask

  task automatic test_reset();
    sclr = 1'b1;
    repeat (2) @(negedge clk);
    sclr = 1'b0;
    @(negedge clk);
    checks++;
    if ({task_ready, task_empty, task_count, busy, error, step_ack, load} !== 13'b1_1_000_0_0000_0_0)
    begin
      failures++;
      $display("FAIL reset_ctrl rdy=%0b empty=%0b cnt=%0d busy=%0b err=%b ack=%0b load=%0b",
               task_ready, task_empty, task_count, busy, error, step_ack, load);
    end
    checks++;
    if (done_cnt !== 32'd0 || ts !== 32'd0 || mask !== '0 || dir !== '0 || n_abs !== '0 ||
        v0 !== '0) begin
      failures++; $display("FAIL reset_data done=%0d ts=%0d mask=%h want zeros", done_cnt, ts, mask);
    end
  endtask

  task automatic test_basic();
    logic [255:0] n;
    exp_t e;
    int lc0;
    n = '0; n[31:0] = 32'hFFFF_FFFB; n[95:64] = 32'd100;
    push_task(32'd1000, n, rand_v0());
    comp_rdy = '0; step_req = 1'b1; lc0 = load_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (load_cnt !== lc0 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_wait loads=%0d busy=%0b want %0d 1", load_cnt, busy, lc0);
    end
    comp_rdy = '1;
    for (int i = 0; i < 20 && load !== 1'b1; i++) @(negedge clk);
    checks++;
    if (load !== 1'b1) begin failures++; $display("FAIL basic_load load=%0b want 1", load); end
    e = sb.pop_front(); model_cnt--;
    checks++;
    if (mask !== 8'h05 || dir !== 8'h01 || n_abs[23:0] !== 24'd5 || n_abs[71:48] !== 24'd100)
    begin
      failures++;
      $display("FAIL basic_decode mask=%h dir=%h n0=%0d n2=%0d want 05 01 5 100",
               mask, dir, n_abs[23:0], n_abs[71:48]);
    end
    checks++;
    if (ts !== e.ts || n_abs !== e.nabs || v0 !== e.v0) begin
      failures++; $display("FAIL basic_fields ts=%0d want %0d v0=%h want %h", ts, e.ts, v0, e.v0);
    end
    comp_rdy = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (step_ack !== 1'b0) begin failures++; $display("FAIL basic_early_ack ack=%0b", step_ack); end
    comp_rdy = '1;
    @(negedge clk);
    model_done++;
    checks++;
    if (step_ack !== 1'b1 || done_cnt !== 32'd1 || load_cnt !== lc0 + 1) begin
      failures++;
      $display("FAIL basic_ack ack=%0b done=%0d loads=%0d want 1 1 %0d",
               step_ack, done_cnt, load_cnt, lc0 + 1);
    end
    step_req = 1'b0;
    @(negedge clk);
    checks++;
    if (step_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_release ack=%0b busy=%0b want 0 0", step_ack, busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [255:0] n;
    for (int i = 0; i < 5; i++) begin
      n = '0; n[31:0] = 32'(i + 1); n[223:192] = 32'h00FF_FFFF; n[255:224] = 32'hFF00_0001;
      push_task(32'(100 + i), n, rand_v0());
    end
    checks++;
    if (task_ready !== 1'b0 || task_count !== 3'd4 || task_empty !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full rdy=%0b cnt=%0d empty=%0b want 0 4 0",
               task_ready, task_count, task_empty);
    end
    step_once(3);
    n = '0; n[63:32] = 32'hFFFF_FFFF;
    push_task(32'd200, n, rand_v0());
    checks++;
    if (task_count !== 3'd4 || task_ready !== 1'b0) begin
      failures++; $display("FAIL fifo_refill cnt=%0d rdy=%0b want 4 0", task_count, task_ready);
    end
    repeat (4) step_once(0);
    checks++;
    if (task_empty !== 1'b1 || task_count !== 3'd0) begin
      failures++; $display("FAIL fifo_drain empty=%0b cnt=%0d want 1 0", task_empty, task_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] n;
    exp_t e;
    n = '0; n[159:128] = 32'd7;
    push_task(32'd300, n, rand_v0());
    push_task(32'd301, n, rand_v0());
    step_req = 1'b1; comp_rdy = '1;
    task_valid = 1'b1; task_ts = 32'd302; task_n = n; task_v0 = rand_v0();
    sb.push_back(model(task_ts, task_n, task_v0));
    @(negedge clk);
    task_valid = 1'b0;
    checks++;
    if (task_count !== 3'd2) begin
      failures++; $display("FAIL push_pop_count cnt=%0d want 2", task_count);
    end
    for (int i = 0; i < 20 && load !== 1'b1; i++) @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (load !== 1'b1 || ts !== e.ts) begin
      failures++; $display("FAIL push_pop_load load=%0b ts=%0d want 1 %0d", load, ts, e.ts);
    end
    for (int i = 0; i < 20 && step_ack !== 1'b1; i++) @(negedge clk);
    model_done++;
    step_req = 1'b0;
    @(negedge clk);
    repeat (2) step_once(1);
  endtask

  task automatic test_range();
    logic [31:0] bad [2];
    logic [255:0] n;
    exp_t e;
    int lc0;
    bad[0] = 32'h0100_0000; bad[1] = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      n = '0; n[127:96] = bad[k];
      push_task(32'd400 + 32'(k), n, rand_v0());
      n = '0; n[31:0] = 32'd1;
      push_task(32'd500, n, rand_v0());
      lc0 = load_cnt; step_req = 1'b1;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (error !== 4'b0010 || busy !== 1'b1 || task_ready !== 1'b0 || task_count !== 3'd1) begin
        failures++;
        $display("FAIL range_err k=%0d err=%b busy=%0b rdy=%0b cnt=%0d want 0010 1 0 1",
                 k, error, busy, task_ready, task_count);
      end
      checks++;
      if (mask !== e.mask || dir !== e.dir || ts !== e.ts) begin
        failures++; $display("FAIL range_regs mask=%h dir=%h want %h %h", mask, dir, e.mask, e.dir);
      end
      step_req = 1'b0;
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      sb.delete(); model_cnt = 0;
      checks++;
      if (busy !== 1'b0 || task_empty !== 1'b1 || error !== 4'b0 || task_ready !== 1'b1 ||
          load_cnt !== lc0) begin
        failures++;
        $display("FAIL range_clr busy=%0b empty=%0b err=%b rdy=%0b loads=%0d want 0 1 0000 1 %0d",
                 busy, task_empty, error, task_ready, load_cnt, lc0);
      end
    end
  endtask

  task automatic test_timeout();
    logic [255:0] n;
    exp_t e;
    int lc0;
    n = '0; n[31:0] = 32'd9;
    push_task(32'd600, n, rand_v0());
    comp_rdy = 8'hFE; step_req = 1'b1; lc0 = load_cnt;
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (error !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early err=%b busy=%0b want 0000 1", error, busy);
    end
    @(negedge clk);
    e = sb.pop_front(); model_cnt--;
    checks++;
    if (error !== 4'b0100 || load_cnt !== lc0 || ts !== e.ts) begin
      failures++;
      $display("FAIL timeout_err err=%b loads=%0d ts=%0d want 0100 %0d %0d",
               error, load_cnt, ts, lc0, e.ts);
    end
    step_req = 1'b0; comp_rdy = '1; err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || error !== 4'b0) begin
      failures++; $display("FAIL timeout_clr busy=%0b err=%b want 0 0000", busy, error);
    end
  endtask

  task automatic test_abort();
    logic [255:0] n;
    exp_t e;
    n = '0; n[63:32] = 32'd3;
    push_task(32'd700, n, rand_v0());
    push_task(32'd701, n, rand_v0());
    step_req = 1'b1; comp_rdy = '1;
    for (int i = 0; i < 20 && load !== 1'b1; i++) @(negedge clk);
    e = sb.pop_front(); model_cnt--;
    checks++;
    if (load !== 1'b1 || ts !== e.ts) begin
      failures++; $display("FAIL abort_load load=%0b ts=%0d want 1 %0d", load, ts, e.ts);
    end
    abort = 1'b1; err_clr = 1'b1; comp_rdy = '0;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (error !== 4'b0001 || step_ack !== 1'b0 || load !== 1'b0 || busy !== 1'b1 ||
        task_count !== 3'd1 || task_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_err err=%b ack=%0b load=%0b busy=%0b cnt=%0d rdy=%0b",
               error, step_ack, load, busy, task_count, task_ready);
    end
    @(negedge clk);
    err_clr = 1'b0; step_req = 1'b0; comp_rdy = '1;
    sb.delete(); model_cnt = 0;
    checks++;
    if (busy !== 1'b0 || error !== 4'b0 || task_empty !== 1'b1) begin
      failures++;
      $display("FAIL abort_clr busy=%0b err=%b empty=%0b want 0 0000 1", busy, error, task_empty);
    end
  endtask

  task automatic test_calc_error();
    logic [255:0] n;
    n = '0; n[31:0] = 32'd4;
    push_task(32'd800, n, rand_v0());
    comp_rdy = '0; step_req = 1'b1;
    @(negedge clk);
    calc_error = 1'b1;
    @(negedge clk);
    calc_error = 1'b0; step_req = 1'b0; comp_rdy = '1;
    void'(sb.pop_front()); model_cnt--;
    checks++;
    if (error !== 4'b1000 || busy !== 1'b1 || load !== 1'b0) begin
      failures++;
      $display("FAIL calc_err err=%b busy=%0b load=%0b want 1000 1 0", error, busy, load);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || error !== 4'b0) begin
      failures++; $display("FAIL calc_clr busy=%0b err=%b want 0 0000", busy, error);
    end
  endtask

  task automatic test_sclr_in_ack();
    logic [255:0] n;
    exp_t e;
    n = '0; n[31:0] = 32'd2;
    push_task(32'd900, n, rand_v0());
    push_task(32'd901, n, rand_v0());
    step_req = 1'b1; comp_rdy = '1;
    for (int i = 0; i < 20 && step_ack !== 1'b1; i++) @(negedge clk);
    e = sb.pop_front(); model_done++;
    checks++;
    if (step_ack !== 1'b1 || done_cnt !== model_done || ts !== e.ts) begin
      failures++;
      $display("FAIL sclr_pre ack=%0b done=%0d ts=%0d want 1 %0d %0d",
               step_ack, done_cnt, ts, model_done, e.ts);
    end
    sclr = 1'b1;
    @(negedge clk);
    sb.delete(); model_cnt = 0; model_done = '0;
    checks++;
    if (busy !== 1'b0 || step_ack !== 1'b0 || done_cnt !== 32'd0 || task_empty !== 1'b1 ||
        error !== 4'b0) begin
      failures++;
      $display("FAIL sclr_ack busy=%0b ack=%0b done=%0d empty=%0b err=%b",
               busy, step_ack, done_cnt, task_empty, error);
    end
    sclr = 1'b0; step_req = 1'b0;
    @(negedge clk);
    checks++;
    if (task_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL sclr_release rdy=%0b busy=%0b want 1 0", task_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_back_to_back();
    test_range();
    test_timeout();
    test_abort();
    test_calc_error();
    test_sclr_in_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
